// File: rtl/cpu_single_cycle.sv
// cpu_single_cycle: single-cycle MIPS-subset core with internal instruction/data memories.
// Register file and memories hold their contents through reset; only the PC is cleared.
module pc_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] D,
    output logic [31:0] Q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) Q <= 32'd0;
        else      Q <= D;
endmodule

module inst_mem #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);
    logic [31:0] memory [0:WORDS-1];
    assign instr = memory[addr];
endmodule

module data_mem #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] memory [0:WORDS-1];
    assign rd = memory[addr];
    always_ff @(posedge clk)
        if (we) memory[addr] <= wd;
endmodule

module cpu_single_cycle #(
    parameter int IM_WORDS = 256,
    parameter int DM_WORDS = 256
) (
    input  logic clk,
    input  logic rst,
    output logic Overflow
);
    localparam int IW = $clog2(IM_WORDS);
    localparam int DW = $clog2(DM_WORDS);

    logic [31:0] pc_q, pc_d, pc4, instr, imm, rs_v, rt_v, op_b, sum, diff, alu, dm_rd, wd;
    logic [31:0] rf_q [0:31];
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, wa;
    logic        r_t, is_add, is_sub, is_and, is_or, is_slt, r_ok;
    logic        is_addi, is_lw, is_sw, is_beq, is_j, we;
    logic        unused_ok;

    pc_reg b2v_PC (.clk(clk), .rst(rst), .D(pc_d), .Q(pc_q));

    inst_mem #(.WORDS(IM_WORDS), .AW(IW)) b2v_im (.addr(pc_q[IW+1:2]), .instr(instr));

    // Writes are gated by rst so an edge during reset cannot commit the aborted instruction.
    data_mem #(.WORDS(DM_WORDS), .AW(DW)) b2v_DM (
        .clk(clk), .we(rst && is_sw), .addr(sum[DW+1:2]), .wd(rt_v), .rd(dm_rd)
    );

    assign op        = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign fn        = instr[5:0];
    assign unused_ok = ^instr[10:6];

    assign r_t     = op == 6'h00;
    assign is_add  = r_t && fn == 6'h20;
    assign is_sub  = r_t && fn == 6'h22;
    assign is_and  = r_t && fn == 6'h24;
    assign is_or   = r_t && fn == 6'h25;
    assign is_slt  = r_t && fn == 6'h2A;
    assign r_ok    = is_add || is_sub || is_and || is_or || is_slt;
    assign is_addi = op == 6'h08;
    assign is_lw   = op == 6'h23;
    assign is_sw   = op == 6'h2B;
    assign is_beq  = op == 6'h04;
    assign is_j    = op == 6'h02;

    assign imm  = {{16{instr[15]}}, instr[15:0]};
    assign rs_v = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_v = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign op_b = r_t ? rt_v : imm;
    assign sum  = rs_v + op_b;
    assign diff = rs_v - rt_v;

    assign alu = is_sub ? diff :
                 is_and ? (rs_v & rt_v) :
                 is_or  ? (rs_v | rt_v) :
                 is_slt ? {31'd0, $signed(rs_v) < $signed(rt_v)} : sum;

    assign Overflow = (is_add || is_addi) ? (rs_v[31] == op_b[31] && sum[31] != rs_v[31]) :
                      is_sub ? (rs_v[31] != rt_v[31] && diff[31] != rs_v[31]) : 1'b0;

    assign wa = r_t ? rd : rt;
    assign we = rst && (r_ok || is_addi || is_lw);
    assign wd = is_lw ? dm_rd : alu;

    always_ff @(posedge clk)
        if (we && wa != 5'd0) rf_q[wa] <= wd;

    assign pc4  = pc_q + 32'd4;
    assign pc_d = is_j ? {pc4[31:28], instr[25:0], 2'b00} :
                  (is_beq && rs_v == rt_v) ? pc4 + {imm[29:0], 2'b00} : pc4;
endmodule

// File: tb/tb_cpu_single_cycle.sv
// tb_cpu_single_cycle: directed program checks plus a randomized ALU program against a reference model.
module tb_cpu_single_cycle;
    logic clk, rst, Overflow;
    int   passes, total;

    cpu_single_cycle dut (.clk(clk), .rst(rst), .Overflow(Overflow));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tg);
        return {6'h02, tg};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drops reset between edges, confirms the PC clears without a clock, and blanks IM to NOPs.
    task automatic restart();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_reset_pc", dut.b2v_PC.Q, 32'd0);
        for (int i = 0; i < 256; i++) dut.b2v_im.memory[i] = 32'd0;
    endtask

    task automatic go();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] m [0:7];
        logic [31:0] prog [0:39];
        int          kind [0:39];
        logic [31:0] a, b, res, v;
        logic [31:0] sorted [0:11];
        logic [31:0] init [0:11];
        logic [4:0]  s, t, d, dst;
        logic [15:0] im;
        longint      r;
        logic        eov, ov_seen;
        passes = 0;
        total  = 0;
        rst    = 1'b0;
        @(negedge clk);
        chk("reset_pc", dut.b2v_PC.Q, 32'd0);

        restart();
        dut.b2v_im.memory[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd512);
        dut.b2v_im.memory[1] = enc_i(6'h08, 5'd0, 5'd17, 16'd12);
        dut.b2v_im.memory[2] = enc_r(6'h2A, 5'd0, 5'd17, 5'd8);
        go();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ov_basic%0d", i), {31'd0, Overflow}, 32'd0);
            step();
        end
        chk("s0", dut.rf_q[16], 32'd512);
        chk("s1", dut.rf_q[17], 32'd12);
        chk("slt_t0", dut.rf_q[8], 32'd1);
        chk("pc_seq", dut.b2v_PC.Q, 32'd12);

        restart();
        dut.b2v_DM.memory[128] = 32'd55;
        dut.b2v_DM.memory[129] = 32'd88;
        dut.b2v_im.memory[0] = enc_i(6'h08, 5'd0, 5'd16, 16'd512);
        dut.b2v_im.memory[1] = enc_i(6'h23, 5'd16, 5'd8, 16'd0);
        dut.b2v_im.memory[2] = enc_i(6'h23, 5'd16, 5'd9, 16'd4);
        dut.b2v_im.memory[3] = enc_i(6'h2B, 5'd16, 5'd9, 16'd0);
        dut.b2v_im.memory[4] = enc_i(6'h2B, 5'd16, 5'd8, 16'd4);
        go();
        repeat (5) step();
        chk("swap_dm128", dut.b2v_DM.memory[128], 32'd88);
        chk("swap_dm129", dut.b2v_DM.memory[129], 32'd55);

        restart();
        dut.b2v_im.memory[0]  = enc_i(6'h08, 5'd0, 5'd17, 16'd12);
        dut.b2v_im.memory[7]  = enc_i(6'h04, 5'd0, 5'd0, 16'd17);
        dut.b2v_im.memory[25] = enc_j(26'd9);
        dut.b2v_im.memory[9]  = enc_i(6'h04, 5'd0, 5'd17, 16'd5);
        go();
        repeat (8) step();
        chk("beq_taken", dut.b2v_PC.Q, 32'd100);
        step();
        chk("jump", dut.b2v_PC.Q, 32'd36);
        step();
        chk("beq_not_taken", dut.b2v_PC.Q, 32'd40);

        restart();
        dut.b2v_im.memory[0] = enc_i(6'h08, 5'd0, 5'd18, 16'd5);
        go();
        step();
        chk("pre_reset_r18", dut.rf_q[18], 32'd5);
        chk("pre_reset_pc", dut.b2v_PC.Q, 32'd4);
        restart();
        dut.b2v_im.memory[0] = enc_i(6'h08, 5'd0, 5'd18, 16'd77);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("no_write_in_reset", dut.rf_q[18], 32'd5);
        chk("pc_held_in_reset", dut.b2v_PC.Q, 32'd0);
        go();
        step();
        chk("first_after_reset", dut.rf_q[18], 32'd77);
        chk("pc_after_reset", dut.b2v_PC.Q, 32'd4);

        restart();
        dut.b2v_DM.memory[140] = 32'h7fffffff;
        dut.b2v_im.memory[0]  = enc_i(6'h23, 5'd0, 5'd8, 16'd560);
        dut.b2v_im.memory[1]  = enc_j(26'd26);
        dut.b2v_im.memory[26] = enc_i(6'h08, 5'd8, 5'd8, 16'd1);
        dut.b2v_im.memory[27] = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
        dut.b2v_im.memory[28] = enc_r(6'h22, 5'd8, 5'd9, 5'd10);
        dut.b2v_im.memory[29] = enc_r(6'h2A, 5'd8, 5'd9, 5'd11);
        go();
        chk("ov_lw", {31'd0, Overflow}, 32'd0);
        step();
        step();
        chk("pc_104", dut.b2v_PC.Q, 32'd104);
        chk("ov_addi", {31'd0, Overflow}, 32'd1);
        step();
        chk("addi_wrap", dut.rf_q[8], 32'h80000000);
        chk("ov_addi_small", {31'd0, Overflow}, 32'd0);
        step();
        chk("ov_sub", {31'd0, Overflow}, 32'd1);
        step();
        chk("sub_wrap", dut.rf_q[10], 32'h7fffffff);
        chk("ov_slt", {31'd0, Overflow}, 32'd0);
        step();
        chk("slt_signed", dut.rf_q[11], 32'd1);

        restart();
        init   = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};
        sorted = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
        for (int i = 0; i < 12; i++) dut.b2v_DM.memory[128+i] = init[i];
        dut.b2v_im.memory[0]  = enc_i(6'h08, 5'd0, 5'd16, 16'd512);
        dut.b2v_im.memory[1]  = enc_i(6'h08, 5'd0, 5'd17, 16'd11);
        dut.b2v_im.memory[4]  = enc_r(6'h20, 5'd16, 5'd0, 5'd19);
        dut.b2v_im.memory[5]  = enc_r(6'h20, 5'd17, 5'd0, 5'd20);
        dut.b2v_im.memory[6]  = enc_i(6'h23, 5'd19, 5'd8, 16'd0);
        dut.b2v_im.memory[7]  = enc_i(6'h23, 5'd19, 5'd9, 16'd4);
        dut.b2v_im.memory[8]  = enc_r(6'h2A, 5'd9, 5'd8, 5'd10);
        dut.b2v_im.memory[9]  = enc_i(6'h04, 5'd10, 5'd0, 16'd2);
        dut.b2v_im.memory[10] = enc_i(6'h2B, 5'd19, 5'd9, 16'd0);
        dut.b2v_im.memory[11] = enc_i(6'h2B, 5'd19, 5'd8, 16'd4);
        dut.b2v_im.memory[12] = enc_i(6'h08, 5'd19, 5'd19, 16'd4);
        dut.b2v_im.memory[13] = enc_i(6'h08, 5'd20, 5'd20, 16'hffff);
        dut.b2v_im.memory[14] = enc_i(6'h04, 5'd20, 5'd0, 16'd1);
        dut.b2v_im.memory[15] = enc_j(26'd6);
        dut.b2v_im.memory[16] = enc_i(6'h08, 5'd17, 5'd17, 16'hffff);
        dut.b2v_im.memory[17] = enc_i(6'h04, 5'd17, 5'd0, 16'd1);
        dut.b2v_im.memory[18] = enc_j(26'd4);
        dut.b2v_im.memory[19] = enc_j(26'd26);
        go();
        ov_seen = 1'b0;
        for (int c = 0; c < 5000 && dut.b2v_PC.Q != 32'd104; c++) begin
            if (Overflow !== 1'b0) ov_seen = 1'b1;
            step();
        end
        chk("sort_reached_104", dut.b2v_PC.Q, 32'd104);
        chk("sort_no_overflow", {31'd0, ov_seen}, 32'd0);
        for (int i = 0; i < 12; i++)
            chk($sformatf("sorted%0d", i), dut.b2v_DM.memory[128+i], sorted[i]);

        restart();
        m[0] = 32'd0;
        for (int k = 1; k < 8; k++) begin
            v = $urandom;
            dut.b2v_DM.memory[k] = v;
            m[k] = v;
            dut.b2v_im.memory[k-1] = enc_i(6'h23, 5'd0, 5'(k), 16'(4*k));
        end
        for (int i = 0; i < 40; i++) begin
            kind[i] = $urandom_range(0, 5);
            s  = 5'($urandom_range(0, 7));
            t  = 5'($urandom_range(0, 7));
            d  = 5'($urandom_range(0, 7));
            im = 16'($urandom);
            case (kind[i])
                0: prog[i] = enc_r(6'h20, s, t, d);
                1: prog[i] = enc_r(6'h22, s, t, d);
                2: prog[i] = enc_r(6'h24, s, t, d);
                3: prog[i] = enc_r(6'h25, s, t, d);
                4: prog[i] = enc_r(6'h2A, s, t, d);
                default: prog[i] = enc_i(6'h08, s, t, im);
            endcase
            dut.b2v_im.memory[7+i] = prog[i];
        end
        go();
        repeat (7) step();
        for (int i = 0; i < 40; i++) begin
            s   = prog[i][25:21];
            t   = prog[i][20:16];
            a   = m[s];
            b   = (kind[i] == 5) ? {{16{prog[i][15]}}, prog[i][15:0]} : m[t];
            dst = (kind[i] == 5) ? t : prog[i][15:11];
            r   = (kind[i] == 1) ? longint'($signed(a)) - longint'($signed(b))
                                 : longint'($signed(a)) + longint'($signed(b));
            eov = (kind[i] == 0 || kind[i] == 1 || kind[i] == 5) &&
                  (r > 64'sd2147483647 || r < -64'sd2147483648);
            res = (kind[i] == 2) ? (a & b) :
                  (kind[i] == 3) ? (a | b) :
                  (kind[i] == 4) ? ((longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0) : r[31:0];
            chk($sformatf("rand_ov%0d", i), {31'd0, Overflow}, {31'd0, eov});
            if (dst != 5'd0) m[dst] = res;
            step();
        end
        for (int k = 1; k < 8; k++)
            chk($sformatf("rand_reg%0d", k), dut.rf_q[k], m[k]);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
